pong_frame_renderer: RTL and testbench

Raster-scan pixel generator for the Pong display: it snapshots the game state once per frame and streams one pixel per accepted beat, row-major, over a valid/ready interface to the matrix driver. The frame contains clamped paddles, the ball, a dashed centre line, and two 3x5 score digits. It generalises the fixed 64x64 combinational matrix image into a parametrised, back-pressured, frame-coherent renderer that sits between the game logic and the LED panel driver.

---
 rtl/pong_frame_renderer.sv | 193 +++++++++++++++++++
 tb/tb_pong_frame_renderer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_renderer.sv
// rtl/pong_frame_renderer.sv - frame-coherent Pong raster renderer with valid/ready pixel stream
// Optional score glyphs are built when SCORE_DISPLAY_EN is defined.
module pong_frame_renderer #(
  parameter int COLS       = 64,
  parameter int ROWS       = 64,
  parameter int CW         = 6,
  parameter int PADDLE_LEN = 6,
  parameter int PADDLE_W   = 2,
  parameter int P1_COL     = 0,
  parameter int P2_COL     = 62,
  parameter int PADDLE_MIN = 5,
  parameter int PADDLE_MAX = 58,
  parameter int MID_COL    = 30,
  parameter int MID_ROWS   = 22,
  parameter int SC_ROW     = 1,
  parameter int SC1_COL    = 14,
  parameter int SC2_COL    = 46
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [CW-1:0] ball_x,
  input  logic [CW-1:0] ball_y,
  input  logic [CW-1:0] p1_y,
  input  logic [CW-1:0] p2_y,
  input  logic [3:0]    score1,
  input  logic [3:0]    score2,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_on,
  output logic [CW-1:0] pix_col,
  output logic [CW-1:0] pix_row,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LATCH, SCAN} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] bx_q, by_q, p1_q, p2_q;
  logic [1:0]    m3_q, nm;
  logic          accept, load;
  logic          on_d, ball_hit, pad_hit, mid_hit, score_hit;
  int            nc, nr, bx, by, q1, q2;

  function automatic int clamp_row(input logic [CW-1:0] p);
    if (int'(p) < PADDLE_MIN) return PADDLE_MIN;
    if (int'(p) > PADDLE_MAX) return PADDLE_MAX;
    return int'(p);
  endfunction

`ifdef SCORE_DISPLAY_EN
  logic [3:0] s1_q, s2_q, s1, s2;

  // Rows packed top row first in the high bits; bit 2 of a row is the leftmost column.
  function automatic logic [2:0] glyph_row(input logic [3:0] d, input int r);
    logic [14:0] g, sh;
    case (d)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b010_010_010_010_010;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_111_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      default: g = 15'b111_101_111_001_111;
    endcase
    sh = g >> (3 * (4 - r));
    return sh[2:0];
  endfunction

  function automatic logic digit_hit(input int c, input int r, input int left, input logic [3:0] d);
    logic [2:0] gr;
    int dr, dc;
    dr = r - SC_ROW;
    dc = c - left;
    if (dr < 0 || dr > 4 || dc < 0 || dc > 2) return 1'b0;
    gr = glyph_row(d, dr);
    return gr[2 - dc];
  endfunction
`else
  logic unused_scores;
  assign unused_scores = ^{score1, score2};
`endif

  assign accept = pix_valid && pix_ready;
  assign load   = (state_q == LATCH) || (accept && !pix_eof);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = LATCH;
      LATCH:   state_d = SCAN;
      SCAN:    if (accept && pix_eof) state_d = enable ? LATCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next pixel is rendered from live inputs while latching so the first beat is ready immediately.
  always_comb begin
    nc = 0;
    nr = 0;
    nm = 2'd0;
    bx = int'(bx_q);
    by = int'(by_q);
    q1 = int'(p1_q);
    q2 = int'(p2_q);
`ifdef SCORE_DISPLAY_EN
    s1 = s1_q;
    s2 = s2_q;
`endif
    if (state_q == LATCH) begin
      bx = int'(ball_x);
      by = int'(ball_y);
      q1 = clamp_row(p1_y);
      q2 = clamp_row(p2_y);
`ifdef SCORE_DISPLAY_EN
      s1 = score1;
      s2 = score2;
`endif
    end else if (int'(pix_col) == COLS - 1) begin
      nr = int'(pix_row) + 1;
      nm = (m3_q == 2'd2) ? 2'd0 : m3_q + 2'd1;
    end else begin
      nc = int'(pix_col) + 1;
      nr = int'(pix_row);
      nm = m3_q;
    end
    ball_hit = (nc == bx) && (nr == by);
    pad_hit  = ((nc >= P1_COL) && (nc < P1_COL + PADDLE_W) && (nr >= q1) && (nr < q1 + PADDLE_LEN))
            || ((nc >= P2_COL) && (nc < P2_COL + PADDLE_W) && (nr >= q2) && (nr < q2 + PADDLE_LEN));
    mid_hit  = (nc == MID_COL) && (nr < MID_ROWS) && (nm != 2'd2);
`ifdef SCORE_DISPLAY_EN
    score_hit = digit_hit(nc, nr, SC1_COL, (s1 > 4'd9) ? 4'd9 : s1)
             || digit_hit(nc, nr, SC2_COL, (s2 > 4'd9) ? 4'd9 : s2);
`else
    score_hit = 1'b0;
`endif
    on_d = ball_hit || pad_hit || mid_hit || score_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bx_q      <= '0;
      by_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      m3_q      <= '0;
      pix_valid <= 1'b0;
      pix_on    <= 1'b0;
      pix_col   <= '0;
      pix_row   <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_eof   <= 1'b0;
`ifdef SCORE_DISPLAY_EN
      s1_q      <= '0;
      s2_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == LATCH) begin
        bx_q <= ball_x;
        by_q <= ball_y;
        p1_q <= CW'(clamp_row(p1_y));
        p2_q <= CW'(clamp_row(p2_y));
`ifdef SCORE_DISPLAY_EN
        s1_q <= score1;
        s2_q <= score2;
`endif
      end
      if (load) begin
        pix_valid <= 1'b1;
        pix_on    <= on_d;
        pix_col   <= CW'(nc);
        pix_row   <= CW'(nr);
        m3_q      <= nm;
        pix_sof   <= (nc == 0) && (nr == 0);
        pix_eol   <= (nc == COLS - 1);
        pix_eof   <= (nc == COLS - 1) && (nr == ROWS - 1);
      end else if (accept) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb/tb_pong_frame_renderer.sv - directed bench for pong_frame_renderer
module tb_pong_frame_renderer;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst, enable, pix_ready;
  logic [CW-1:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0]    score1, score2;
  logic          pix_valid, pix_on, pix_sof, pix_eol, pix_eof, busy;
  logic [CW-1:0] pix_col, pix_row;

  int n_assert = 0;
  int n_fail   = 0;
  int seq_err  = 0;
  int beats    = 0;
  bit done     = 0;
  bit frame [0:63][0:63];

  always #5 clk = ~clk;

  pong_frame_renderer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .score1(score1), .score2(score2),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_on(pix_on),
    .pix_col(pix_col), .pix_row(pix_row),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Streams until eof is presented with ready (or stop_at beats), checking order, flags and stall hold.
  task automatic run_frame(input bit rnd, input int stop_at, input int mod_at);
    int ec, er;
    bit held, rdy;
    logic [3+2*CW:0] saved, cur;
    ec = 0; er = 0; held = 0; saved = '0;
    beats = 0; seq_err = 0; done = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) frame[r][c] = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      cur = {pix_on, pix_sof, pix_eol, pix_eof, pix_col, pix_row};
      if (held && cur !== saved) seq_err++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_ready = rdy;
      held  = pix_valid && !rdy;
      saved = cur;
      if (pix_valid && rdy) begin
        if (int'(pix_col) != ec || int'(pix_row) != er
            || pix_sof !== (ec == 0 && er == 0)
            || pix_eol !== (ec == 63)
            || pix_eof !== (ec == 63 && er == 63)) seq_err++;
        frame[pix_row][pix_col] = pix_on;
        beats++;
        if (pix_eof) done = 1;
        if (ec == 63) begin ec = 0; er++; end else ec++;
        if (beats == mod_at) begin
          ball_x = 40; ball_y = 50; p1_y = 40; p2_y = 10;
          score1 = 7; score2 = 7; enable = 1'b0;
        end
        if (beats == stop_at) done = 1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
  endtask

  function automatic int count_lit();
    int n = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) n += int'(frame[r][c]);
    return n;
  endfunction

  function automatic int count_mid();
    int n = 0;
    for (int r = 0; r < 64; r++) n += int'(frame[r][30]);
    return n;
  endfunction

  initial begin
    logic [2:0] g2 [5];
    logic [2:0] g9 [5];
    logic [2:0] e1, e2;
    g2 = '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111};
    g9 = '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111};

    rst = 1'b1; enable = 1'b0; pix_ready = 1'b0;
    ball_x = 10; ball_y = 20; p1_y = 30; p2_y = 40; score1 = 0; score2 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_on", pix_on, 0);
    check("rst_sof", pix_sof, 0);
    check("rst_eof", pix_eof, 0);
    check("rst_col", pix_col, 0);

    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("latch_busy", busy, 1);
    check("latch_valid", pix_valid, 0);
    @(posedge clk); #1;
    check("first_valid", pix_valid, 1);
    check("first_sof", pix_sof, 1);
    check("first_col", pix_col, 0);
    check("first_row", pix_row, 0);

    run_frame(0, -1, -1);
    check("f1_done", done, 1);
    check("f1_beats", beats, 4096);
    check("f1_seq", seq_err, 0);
    check("f1_ball", frame[20][10], 1);
    check("f1_p1_top", frame[30][0], 1);
    check("f1_p1_bot", frame[35][1], 1);
    check("f1_p1_below", frame[36][0], 0);
    check("f1_p1_above", frame[29][1], 0);
    check("f1_p2_top", frame[40][62], 1);
    check("f1_p2_bot", frame[45][63], 1);
    check("f1_p2_below", frame[46][63], 0);
    check("f1_mid_count", count_mid(), 15);
    check("f1_mid_r20", frame[20][30], 0);
    check("f1_mid_r21", frame[21][30], 1);
    check("f1_mid_r22", frame[22][30], 0);
`ifdef SCORE_DISPLAY_EN
    check("f1_sc1_row0", {frame[1][14], frame[1][15], frame[1][16]}, 3'b111);
    check("f1_sc1_row1", {frame[2][14], frame[2][15], frame[2][16]}, 3'b101);
    check("f1_lit_total", count_lit(), 64);
`else
    check("f1_sc1_row0", {frame[1][14], frame[1][15], frame[1][16]}, 3'b000);
    check("f1_lit_total", count_lit(), 40);
`endif

    @(posedge clk); #1;
    check("bubble_valid", pix_valid, 0);
    check("bubble_busy", busy, 1);
    p1_y = 0; p2_y = 63; score1 = 2; score2 = 12; ball_x = 5; ball_y = 63;
    @(posedge clk); #1;
    check("f2_valid", pix_valid, 1);
    check("f2_sof", pix_sof, 1);

    run_frame(1, -1, 100);
    check("f2_done", done, 1);
    check("f2_beats", beats, 4096);
    check("f2_seq", seq_err, 0);
    check("f2_p1_top", frame[5][0], 1);
    check("f2_p1_bot", frame[10][1], 1);
    check("f2_p1_above", frame[4][0], 0);
    check("f2_p1_below", frame[11][0], 0);
    check("f2_p2_top", frame[58][62], 1);
    check("f2_p2_bot", frame[63][63], 1);
    check("f2_p2_above", frame[57][63], 0);
    check("f2_ball", frame[63][5], 1);
    check("f2_mid_ball_ignored", frame[50][40], 0);
    check("f2_mid_p2_ignored", frame[10][62], 0);
    for (int r = 0; r < 5; r++) begin
`ifdef SCORE_DISPLAY_EN
      e1 = g2[r]; e2 = g9[r];
`else
      e1 = 3'b000; e2 = 3'b000;
`endif
      check($sformatf("f2_sc1_row%0d", r), {frame[r+1][14], frame[r+1][15], frame[r+1][16]}, e1);
      check($sformatf("f2_sc2_row%0d", r), {frame[r+1][46], frame[r+1][47], frame[r+1][48]}, e2);
    end
`ifdef SCORE_DISPLAY_EN
    check("f2_lit_total", count_lit(), 63);
`else
    check("f2_lit_total", count_lit(), 40);
`endif

    @(posedge clk); #1;
    check("drop_idle_busy", busy, 0);
    check("drop_idle_valid", pix_valid, 0);
    @(posedge clk); #1;
    check("drop_stay_idle", pix_valid, 0);

    enable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    run_frame(0, 1000, -1);
    check("abort_beats", beats, 1000);
    check("abort_seq", seq_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", pix_valid, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("restart_latch", pix_valid, 0);
    @(posedge clk); #1;
    check("restart_valid", pix_valid, 1);
    check("restart_sof", pix_sof, 1);
    check("restart_col", pix_col, 0);
    check("restart_row", pix_row, 0);
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
